// File: rtl/mips_boot_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package mips_boot_pkg;

  // Loader FSM states, in stream order.
  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    TERM,
    DONE,
    ERR
  } boot_state_e;

  // The core halts when it fetches an all-zero instruction.
  localparam logic [31:0] HALT_WORD  = 32'h0000_0000;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles accepted bytes big-endian into 32-bit words.
module byte_packer
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  phase_q, phase_d;
  logic [23:0] hold_q, hold_d;

  // Next phase and holding register: shift in each accepted byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    phase_d = phase_q;
    hold_d  = hold_q;
    if (byte_valid_i) begin
      phase_d = phase_q + 2'd1;
      hold_d  = {hold_q[15:0], byte_i};
    end
  end

  // The final byte of a word completes it in the same cycle it is accepted.
  assign word_valid_o = byte_valid_i && (phase_q == 2'(WORD_BYTES - 1));
  assign word_o       = {hold_q, byte_i};

  // Phase and holding registers; reset drops any partial word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      phase_q <= 2'd0;
      hold_q  <= 24'd0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, appends a
// halt word, then releases the MIPS core from reset.
module imem_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 1);

  boot_state_e       state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       hdr_n;
  logic              word_valid;
  logic [31:0]       word;

  // Bytes are only taken while reading the header or program.
  always_comb begin
    in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
  end

  assign accept = in_valid && in_ready;
  assign hdr_n  = {cnt_q[15:8], in_data};

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state logic and the registered write / status values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    // Core reset and done follow DONE one edge late, after the halt word lands.
    cpu_rst_d = (state_q != DONE);
    done_d    = (state_q == DONE);

    case (state_q)
      HDR_HI: begin
        if (accept) begin
          cnt_d[15:8] = in_data;
          state_d     = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          cnt_d = hdr_n;
          if (32'(hdr_n) > 32'(MAX_WORDS)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (hdr_n == 16'd0) begin
            state_d = TERM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'({widx_q, 2'b00});
          wr_data_d = word;
          widx_d    = widx_q + WIDX_W'(1);
          if ((16'(widx_q) + 16'd1) == cnt_q) begin
            state_d = TERM;
          end
        end
      end
      TERM: begin
        // widx already equals N here, so it addresses the slot after the program.
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'({widx_q, 2'b00});
        wr_data_d = HALT_WORD;
        state_d   = DONE;
      end
      DONE, ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = HDR_HI;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR_HI;
      cnt_q     <= 16'd0;
      widx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cpu_rst = cpu_rst_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a write-log monitor.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks;
  int errors;

  // Log of every write seen on the memory port.
  logic [31:0] log_addr [0:299];
  logic [31:0] log_data [0:299];
  int          wcount;

  imem_loader #(
    .ADDR_W    (32),
    .MAX_WORDS (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record writes between edges.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wcount < 300) begin
        log_addr[wcount] = wr_addr;
        log_data[wcount] = wr_data;
      end
      wcount = wcount + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    wcount = 0;
  endtask

  // Present one byte and return just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int waitc;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    waitc    = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_stall byte=%02h in_ready=%b expected 1", b, in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    if (wr_addr !== 32'h0) begin errors++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
    if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
  endtask

  task automatic test_nominal();
    logic [7:0]  bytes [0:9];
    logic [31:0] ea [0:2];
    logic [31:0] ed [0:2];
    bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    ea = '{32'h0, 32'h4, 32'h8};
    ed = '{32'h20080005, 32'h20090007, 32'h00000000};
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(bytes[i]);
    // Between edges k and k+1: last data word on the port.
    @(negedge clk);
    in_valid = 1'b0;
    checks += 4;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL nom_k_wr_en got=%b exp=1", wr_en); end
    if (wr_addr !== 32'h4) begin errors++; $display("FAIL nom_k_addr got=%h exp=4", wr_addr); end
    if (wr_data !== 32'h20090007) begin errors++; $display("FAIL nom_k_data got=%h exp=20090007", wr_data); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL nom_k_in_ready got=%b exp=0", in_ready); end
    // Between k+1 and k+2: terminator, core still in reset.
    @(negedge clk);
    checks += 5;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL nom_k1_wr_en got=%b exp=1", wr_en); end
    if (wr_addr !== 32'h8) begin errors++; $display("FAIL nom_k1_addr got=%h exp=8", wr_addr); end
    if (wr_data !== 32'h0) begin errors++; $display("FAIL nom_k1_data got=%h exp=0", wr_data); end
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL nom_k1_cpu_rst got=%b exp=1", cpu_rst); end
    if (done !== 1'b0) begin errors++; $display("FAIL nom_k1_done got=%b exp=0", done); end
    // After k+2: core released.
    @(negedge clk);
    checks += 4;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL nom_k2_wr_en got=%b exp=0", wr_en); end
    if (cpu_rst !== 1'b0) begin errors++; $display("FAIL nom_k2_cpu_rst got=%b exp=0", cpu_rst); end
    if (done !== 1'b1) begin errors++; $display("FAIL nom_k2_done got=%b exp=1", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL nom_k2_err got=%b exp=0", err); end
    idle(4);
    checks++;
    if (wcount !== 3) begin errors++; $display("FAIL nom_wcount got=%0d exp=3", wcount); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL nom_write%0d got=(%h,%h) exp=(%h,%h)", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_empty();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    idle(5);
    checks += 5;
    if (wcount !== 1) begin errors++; $display("FAIL empty_wcount got=%0d exp=1", wcount); end
    if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h0) begin
      errors++; $display("FAIL empty_write got=(%h,%h) exp=(0,0)", log_addr[0], log_data[0]);
    end
    if (done !== 1'b1) begin errors++; $display("FAIL empty_done got=%b exp=1", done); end
    if (cpu_rst !== 1'b0) begin errors++; $display("FAIL empty_cpu_rst got=%b exp=0", cpu_rst); end
    if (err !== 1'b0) begin errors++; $display("FAIL empty_err got=%b exp=0", err); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (12) @(negedge clk);
    checks += 5;
    if (err !== 1'b1) begin errors++; $display("FAIL over_err got=%b exp=1", err); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL over_in_ready got=%b exp=0", in_ready); end
    if (wcount !== 0) begin errors++; $display("FAIL over_wcount got=%0d exp=0", wcount); end
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL over_cpu_rst got=%b exp=1", cpu_rst); end
    if (done !== 1'b0) begin errors++; $display("FAIL over_done got=%b exp=0", done); end
    in_valid = 1'b0;
  endtask

  task automatic test_gapped();
    logic [7:0] bytes [0:9];
    bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i]);
      idle(3);
      // Extra gap between the 2nd and 3rd byte of each word.
      if (i == 3 || i == 7) idle(5);
    end
    idle(4);
    checks += 5;
    if (wcount !== 3) begin errors++; $display("FAIL gap_wcount got=%0d exp=3", wcount); end
    if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h20080005) begin
      errors++; $display("FAIL gap_write0 got=(%h,%h) exp=(0,20080005)", log_addr[0], log_data[0]);
    end
    if (log_addr[1] !== 32'h4 || log_data[1] !== 32'h20090007) begin
      errors++; $display("FAIL gap_write1 got=(%h,%h) exp=(4,20090007)", log_addr[1], log_data[1]);
    end
    if (log_addr[2] !== 32'h8 || log_data[2] !== 32'h0) begin
      errors++; $display("FAIL gap_write2 got=(%h,%h) exp=(8,0)", log_addr[2], log_data[2]);
    end
    if (done !== 1'b1) begin errors++; $display("FAIL gap_done got=%b exp=1", done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    // One-cycle synchronous reset pulse.
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wcount !== 0) begin errors++; $display("FAIL mid_partial got=%0d writes exp=0", wcount); end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    idle(5);
    checks += 4;
    if (wcount !== 2) begin errors++; $display("FAIL mid_wcount got=%0d exp=2", wcount); end
    if (log_addr[0] !== 32'h0 || log_data[0] !== 32'hAABBCCDD) begin
      errors++; $display("FAIL mid_write0 got=(%h,%h) exp=(0,aabbccdd)", log_addr[0], log_data[0]);
    end
    if (log_addr[1] !== 32'h4 || log_data[1] !== 32'h0) begin
      errors++; $display("FAIL mid_write1 got=(%h,%h) exp=(4,0)", log_addr[1], log_data[1]);
    end
    if (done !== 1'b1) begin errors++; $display("FAIL mid_done got=%b exp=1", done); end
  endtask

  task automatic test_boundary();
    logic [15:0] idx;
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      idx = 16'(i);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(idx[15:8]);
      send_byte(idx[7:0]);
    end
    idle(5);
    checks += 7;
    if (wcount !== 257) begin errors++; $display("FAIL bnd_wcount got=%0d exp=257", wcount); end
    if (log_addr[0] !== 32'h0 || log_data[0] !== 32'hA5000000) begin
      errors++; $display("FAIL bnd_write0 got=(%h,%h) exp=(0,a5000000)", log_addr[0], log_data[0]);
    end
    if (log_addr[128] !== 32'h200 || log_data[128] !== 32'hA5000080) begin
      errors++; $display("FAIL bnd_write128 got=(%h,%h) exp=(200,a5000080)", log_addr[128], log_data[128]);
    end
    if (log_addr[255] !== 32'h3FC || log_data[255] !== 32'hA50000FF) begin
      errors++; $display("FAIL bnd_write255 got=(%h,%h) exp=(3fc,a50000ff)", log_addr[255], log_data[255]);
    end
    if (log_addr[256] !== 32'h400 || log_data[256] !== 32'h0) begin
      errors++; $display("FAIL bnd_term got=(%h,%h) exp=(400,0)", log_addr[256], log_data[256]);
    end
    if (err !== 1'b0) begin errors++; $display("FAIL bnd_err got=%b exp=0", err); end
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++; $display("FAIL bnd_release got done=%b cpu_rst=%b exp done=1 cpu_rst=0", done, cpu_rst);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wcount   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_empty();
    test_oversize();
    test_gapped();
    test_reset_mid();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
